// File: rtl/turbo_enc_stream.sv
// Rate-1/3 turbo encoder: two lock-step 4-state RSC encoders (natural and stride-permuted order).
// Define TURBO_TAIL_EN to compile in the two-symbol trellis termination (TAIL state).
module turbo_enc_stream #(
    parameter int K      = 8,
    parameter int STRIDE = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [2:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic [1:0]   dbg_state
);
    // Handshake: a word/symbol transfers on a rising clk edge where valid && ready are
    // both high; the valid side holds its data stable until that edge.

    localparam int            IW       = $clog2(K);
    localparam logic [IW-1:0] STRIDE_L = IW'(STRIDE);
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

`ifdef TURBO_TAIL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, TAIL = 2'd2} state_e;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1} state_e;
`endif

    state_e        state_q, state_d;
    logic [K-1:0]  buf_q, buf_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    st1_q, st1_d;
    logic [1:0]    st2_q, st2_d;
`ifdef TURBO_TAIL_EN
    logic          tail_q, tail_d;
`endif

    logic [IW-1:0] perm_idx;
    logic          u1, u2;
    logic [2:0]    step1, step2;

    // Returns {parity, next_state}; state is {s1, s0}, feedback 111, feedforward 101.
    function automatic logic [2:0] rsc_step(input logic u, input logic [1:0] s);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a ^ s[0], a, s[1]};
    endfunction

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        st1_d     = st1_q;
        st2_d     = st2_q;
`ifdef TURBO_TAIL_EN
        tail_d    = tail_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = 3'b000;
        perm_idx  = idx_q * STRIDE_L;
        u1        = buf_q[idx_q];
        u2        = buf_q[perm_idx];
        step1     = 3'b000;
        step2     = 3'b000;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    buf_d   = in_data;
                    idx_d   = '0;
                    st1_d   = 2'b00;
                    st2_d   = 2'b00;
                    state_d = ENC;
                end
            end
            ENC: begin
                out_valid = 1'b1;
                step1     = rsc_step(u1, st1_q);
                step2     = rsc_step(u2, st2_q);
                out_data  = {u1, step1[2], step2[2]};
`ifndef TURBO_TAIL_EN
                out_last  = (idx_q == LAST_IDX);
`endif
                if (out_ready) begin
                    st1_d = step1[1:0];
                    st2_d = step2[1:0];
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == LAST_IDX) begin
`ifdef TURBO_TAIL_EN
                        tail_d  = 1'b0;
                        state_d = TAIL;
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef TURBO_TAIL_EN
            TAIL: begin
                // Feeding u = s1^s0 zeroes the feedback bit, shifting each trellis back to 00.
                out_valid = 1'b1;
                step1     = rsc_step(st1_q[1] ^ st1_q[0], st1_q);
                step2     = rsc_step(st2_q[1] ^ st2_q[0], st2_q);
                out_data  = {st1_q[1] ^ st1_q[0], step1[2], step2[2]};
                out_last  = tail_q;
                if (out_ready) begin
                    st1_d  = step1[1:0];
                    st2_d  = step2[1:0];
                    tail_d = 1'b1;
                    if (tail_q) begin
                        tail_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            st1_q   <= 2'b00;
            st2_q   <= 2'b00;
`ifdef TURBO_TAIL_EN
            tail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            st1_q   <= st1_d;
            st2_q   <= st2_d;
`ifdef TURBO_TAIL_EN
            tail_q  <= tail_d;
`endif
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_turbo_enc_stream.sv
// Self-checking bench for turbo_enc_stream (K=8, STRIDE=3); follows TURBO_TAIL_EN if defined.
module tb_turbo_enc_stream;
    localparam int K      = 8;
    localparam int STRIDE = 3;
`ifdef TURBO_TAIL_EN
    localparam bit TAIL_EN = 1'b1;
    localparam int NSYM    = K + 2;
`else
    localparam bit TAIL_EN = 1'b0;
    localparam int NSYM    = K;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [K-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic [1:0]   dbg_state;

    turbo_enc_stream #(.K(K), .STRIDE(STRIDE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    logic [2:0] known[10];
    int         busy_ready;
    bit         timeout;

    // Reference: symbols {last, sys, p1, p2} from the RSC rules with integer state 0..3.
    function automatic void model_block(input logic [K-1:0] w);
        int st1, st2, u1, u2, a, p1, p2, last;
        st1 = 0;
        st2 = 0;
        exp_q.delete();
        for (int i = 0; i < K; i++) begin
            u1 = int'(w[i]);
            u2 = int'(w[(i * STRIDE) % K]);
            a = u1 ^ (st1 >> 1) ^ (st1 & 1); p1 = a ^ (st1 & 1); st1 = (a << 1) | (st1 >> 1);
            a = u2 ^ (st2 >> 1) ^ (st2 & 1); p2 = a ^ (st2 & 1); st2 = (a << 1) | (st2 >> 1);
            last = (!TAIL_EN && i == K - 1) ? 1 : 0;
            exp_q.push_back({last[0], u1[0], p1[0], p2[0]});
        end
        if (TAIL_EN) begin
            for (int t = 0; t < 2; t++) begin
                u1 = ((st1 >> 1) ^ st1) & 1;
                u2 = ((st2 >> 1) ^ st2) & 1;
                a = u1 ^ (st1 >> 1) ^ (st1 & 1); p1 = a ^ (st1 & 1); st1 = (a << 1) | (st1 >> 1);
                a = u2 ^ (st2 >> 1) ^ (st2 & 1); p2 = a ^ (st2 & 1); st2 = (a << 1) | (st2 >> 1);
                last = (t == 1) ? 1 : 0;
                exp_q.push_back({last[0], u1[0], p1[0], p2[0]});
            end
        end
    endfunction

    task automatic send_word(input logic [K-1:0] w, input bit keep_valid, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic capture(input bit rand_ready);
        int cyc;
        bit done;
        got_q.delete();
        busy_ready = 0;
        timeout = 1'b0;
        done = 1'b0;
        cyc = 0;
        while (!done) begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_ready) busy_ready++;
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                if (out_last) done = 1'b1;
            end
            cyc++;
            if (cyc > 400) begin
                timeout = 1'b1;
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
        n_vec++; if (out_data !== 3'b000) begin n_err++; $display("FAIL reset_out_data got %b want 000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_known(input string tag);
        bit ok;
        send_word(8'h01, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL %s_accept got 0 want 1", tag); end
        capture(1'b0);
        n_vec++; if (got_q.size() !== NSYM || timeout) begin
            n_err++; $display("FAIL %s_len got %0d want %0d", tag, got_q.size(), NSYM);
        end
        for (int i = 0; i < got_q.size() && i < NSYM; i++) begin
            n_vec++;
            if (got_q[i] !== {(i == NSYM - 1), known[i]}) begin
                n_err++; $display("FAIL %s_sym%0d got %b want %b", tag, i, got_q[i], {(i == NSYM - 1), known[i]});
            end
        end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL %s_idle_after got rdy=%b vld=%b want rdy=1 vld=0", tag, in_ready, out_valid);
        end
    endtask

    task automatic test_zero();
        bit ok;
        send_word(8'h00, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL zero_accept got 0 want 1"); end
        capture(1'b0);
        n_vec++; if (got_q.size() !== NSYM || timeout) begin
            n_err++; $display("FAIL zero_len got %0d want %0d", got_q.size(), NSYM);
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== {(i == NSYM - 1), 3'b000}) begin
                n_err++; $display("FAIL zero_sym%0d got %b want %b", i, got_q[i], {(i == NSYM - 1), 3'b000});
            end
        end
        n_vec++; if (busy_ready !== 0) begin n_err++; $display("FAIL zero_busy_ready got %0d want 0", busy_ready); end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready_after got %b want 1", in_ready); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int hs, stall, cyc;
        send_word(8'h01, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL bp_accept got 0 want 1"); end
        got_q.delete();
        hs = 0; stall = 0; cyc = 0;
        while (hs < NSYM && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (hs == 2 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
                n_vec++;
                if (out_valid !== 1'b1 || out_data !== known[2]) begin
                    n_err++; $display("FAIL bp_hold%0d got vld=%b data=%b want vld=1 data=%b", stall, out_valid, out_data, known[2]);
                end
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    got_q.push_back({out_last, out_data});
                    hs++;
                end
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n_vec++; if (got_q.size() !== NSYM) begin n_err++; $display("FAIL bp_len got %0d want %0d", got_q.size(), NSYM); end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== {(i == NSYM - 1), known[i]}) begin
                n_err++; $display("FAIL bp_sym%0d got %b want %b", i, got_q[i], {(i == NSYM - 1), known[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_word(8'h01, 1'b0, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_accept got 0 want 1"); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 3'b000 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL rstmid_outputs got vld=%b last=%b data=%b rdy=%b want 0 0 000 1",
                              out_valid, out_last, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_partial got %b want 0", out_valid); end
        test_known("rstmid");
    endtask

    task automatic test_random();
        bit ok;
        logic [K-1:0] w;
        for (int n = 0; n < 20; n++) begin
            w = K'($urandom());
            model_block(w);
            send_word(w, 1'b0, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_accept got 0 want 1", n); end
            capture(1'b1);
            n_vec++; if (got_q.size() !== exp_q.size() || timeout) begin
                n_err++; $display("FAIL rand%0d_len got %0d want %0d", n, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand%0d_sym%0d word=%h got %b want %b", n, i, w, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_word(8'h01, 1'b1, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_accept1 got 0 want 1"); end
        in_data = 8'hFF;
        model_block(8'h01);
        capture(1'b0);
        n_vec++; if (busy_ready !== 0) begin n_err++; $display("FAIL b2b_busy_ready got %0d want 0", busy_ready); end
        n_vec++; if (got_q.size() !== exp_q.size() || timeout) begin
            n_err++; $display("FAIL b2b_len1 got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_blk1_sym%0d got %b want %b", i, got_q[i], exp_q[i]); end
        end
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_idle_gap got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_block(8'hFF);
        capture(1'b0);
        n_vec++; if (got_q.size() !== exp_q.size() || timeout) begin
            n_err++; $display("FAIL b2b_len2 got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_blk2_sym%0d got %b want %b", i, got_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        known = '{3'b111, 3'b011, 3'b011, 3'b000, 3'b011, 3'b011, 3'b000, 3'b011, 3'b011, 3'b111};
        test_reset();
        test_known("known");
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
